// File: rtl/pipe_pkg.sv
// =============================================================================
// pipe_pkg
// Shared constants, state encoding and the saturating Tnew decrement used by the
// inter-stage pipeline buffer.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

package pipe_pkg;

    localparam int c_TNEW_W   = 2;
    localparam int c_EXC_W    = 5;
    localparam int c_EXC_NONE = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Wide argument so any Tnew width can use it; callers truncate the result.
    function automatic logic [31:0] sat_dec(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : x - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_buf_if.sv
// =============================================================================
// pipe_stage_buf_if
// Upstream/downstream valid-ready handshake bundle for one pipeline boundary.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int TNEW_W = c_TNEW_W,
    parameter int EXC_W  = c_EXC_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [TNEW_W-1:0] in_tnew;
    logic [EXC_W-1:0]  in_exc;
    logic [EXC_W-1:0]  stage_exc;
    logic              in_bd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TNEW_W-1:0] out_tnew;
    logic [EXC_W-1:0]  out_exc;
    logic              out_bd;

    // Environment side: feeds entries in and consumes the head.
    modport master (
        output in_valid, in_data, in_tnew, in_exc, stage_exc, in_bd, out_ready,
        input  in_ready, out_valid, out_data, out_tnew, out_exc, out_bd
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_data, in_tnew, in_exc, stage_exc, in_bd, out_ready,
        output in_ready, out_valid, out_data, out_tnew, out_exc, out_bd
    );
endinterface

`default_nettype wire

// File: rtl/pipe_slot.sv
// =============================================================================
// pipe_slot
// One buffer entry register: load, hold-with-Tnew-decrement, and clear.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int TNEW_W = c_TNEW_W,
    parameter int EXC_W  = c_EXC_W
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_clear,
    input  wire logic              i_load,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic [TNEW_W-1:0] i_tnew,
    input  wire logic [EXC_W-1:0]  i_exc,
    input  wire logic              i_bd,
    output logic      [DATA_W-1:0] o_data,
    output logic      [TNEW_W-1:0] o_tnew,
    output logic      [EXC_W-1:0]  o_exc,
    output logic                   o_bd
);

    logic [DATA_W-1:0] r_data;
    logic [TNEW_W-1:0] r_tnew;
    logic [EXC_W-1:0]  r_exc;
    logic              r_bd;

    logic [TNEW_W-1:0] w_tnew_load;
    logic [TNEW_W-1:0] w_tnew_hold;

    // Every edge an entry lives through costs it one cycle of Tnew.
    assign w_tnew_load = TNEW_W'(sat_dec(32'(i_tnew)));
    assign w_tnew_hold = TNEW_W'(sat_dec(32'(r_tnew)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_tnew <= '0;
            r_exc  <= '0;
            r_bd   <= 1'b0;
        end else if (i_clear) begin
            r_data <= '0;
            r_tnew <= '0;
            r_exc  <= '0;
            r_bd   <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_tnew <= w_tnew_load;
            r_exc  <= i_exc;
            r_bd   <= i_bd;
        end else begin
            r_tnew <= w_tnew_hold;
        end
    end

    assign o_data = r_data;
    assign o_tnew = r_tnew;
    assign o_exc  = r_exc;
    assign o_bd   = r_bd;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// =============================================================================
// pipe_stage_buf
// Two-entry skid buffer between CPU pipeline stages with flush, Tnew countdown
// and first-exception-wins merging.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 160,
    parameter int TNEW_W = c_TNEW_W,
    parameter int EXC_W  = c_EXC_W
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        flush,
    pipe_stage_buf_if.slave  bus
);

    state_t r_state;

    logic w_in_ready;
    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_main_load;
    logic w_skid_load;
    logic w_main_from_skid;

    logic [EXC_W-1:0]  w_exc_merged;

    logic [DATA_W-1:0] w_main_d_in;
    logic [TNEW_W-1:0] w_main_t_in;
    logic [EXC_W-1:0]  w_main_e_in;
    logic              w_main_b_in;

    logic [DATA_W-1:0] w_main_data;
    logic [TNEW_W-1:0] w_main_tnew;
    logic [EXC_W-1:0]  w_main_exc;
    logic              w_main_bd;

    logic [DATA_W-1:0] w_skid_data;
    logic [TNEW_W-1:0] w_skid_tnew;
    logic [EXC_W-1:0]  w_skid_exc;
    logic              w_skid_bd;

    // Handshake flags come from the state register only, so in_ready never
    // combinationally depends on out_ready.
    assign w_in_ready  = (r_state != TWO);
    assign w_out_valid = (r_state != EMPTY);
    assign w_in_fire   = bus.in_valid & w_in_ready & ~flush;
    assign w_out_fire  = w_out_valid & bus.out_ready;

    assign w_exc_merged = (bus.in_exc != EXC_W'(c_EXC_NONE)) ? bus.in_exc : bus.stage_exc;

    assign w_main_from_skid = (r_state == TWO);
    assign w_main_load = (w_in_fire & (r_state == EMPTY))
                       | (w_in_fire & (r_state == ONE) & w_out_fire)
                       | (w_main_from_skid & w_out_fire);
    assign w_skid_load = w_in_fire & (r_state == ONE) & ~w_out_fire;

    // Promotion hands the raw skid Tnew to main, which decrements it on load.
    assign w_main_d_in = w_main_from_skid ? w_skid_data : bus.in_data;
    assign w_main_t_in = w_main_from_skid ? w_skid_tnew : bus.in_tnew;
    assign w_main_e_in = w_main_from_skid ? w_skid_exc  : w_exc_merged;
    assign w_main_b_in = w_main_from_skid ? w_skid_bd   : bus.in_bd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else if (flush) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) r_state <= ONE;
                ONE: begin
                    if (w_in_fire && !w_out_fire)      r_state <= TWO;
                    else if (!w_in_fire && w_out_fire) r_state <= EMPTY;
                end
                TWO:     if (w_out_fire) r_state <= ONE;
                default: r_state <= EMPTY;
            endcase
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .TNEW_W (TNEW_W),
        .EXC_W  (EXC_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_load  (w_main_load),
        .i_data  (w_main_d_in),
        .i_tnew  (w_main_t_in),
        .i_exc   (w_main_e_in),
        .i_bd    (w_main_b_in),
        .o_data  (w_main_data),
        .o_tnew  (w_main_tnew),
        .o_exc   (w_main_exc),
        .o_bd    (w_main_bd)
    );

    pipe_slot #(
        .DATA_W (DATA_W),
        .TNEW_W (TNEW_W),
        .EXC_W  (EXC_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_load  (w_skid_load),
        .i_data  (bus.in_data),
        .i_tnew  (bus.in_tnew),
        .i_exc   (w_exc_merged),
        .i_bd    (bus.in_bd),
        .o_data  (w_skid_data),
        .o_tnew  (w_skid_tnew),
        .o_exc   (w_skid_exc),
        .o_bd    (w_skid_bd)
    );

    // An empty buffer presents a zero payload, i.e. a nop bubble.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_main_data : '0;
    assign bus.out_tnew  = w_out_valid ? w_main_tnew : '0;
    assign bus.out_exc   = w_out_valid ? w_main_exc  : '0;
    assign bus.out_bd    = w_out_valid ? w_main_bd   : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// =============================================================================
// tb_pipe_stage_buf
// Self-checking bench: queue-based reference model plus directed scenarios.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int DATA_W = 160;
    localparam int TNEW_W = 2;
    localparam int EXC_W  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .EXC_W(EXC_W)) bus ();

    pipe_stage_buf #(.DATA_W(DATA_W), .TNEW_W(TNEW_W), .EXC_W(EXC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        int                t;
        logic [EXC_W-1:0]  e;
        logic              b;
    } ent_t;

    ent_t q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered queue of at most two entries; each edge ages all held
    // entries by one, drains the head when taken, then appends a new capture.
    always @(posedge clk or negedge reset) begin
        bit   m_in_fire;
        bit   m_out_fire;
        ent_t e;
        if (!reset) begin
            q.delete();
        end else begin
            m_in_fire  = bus.in_valid && (q.size() < 2) && !flush;
            m_out_fire = (q.size() > 0) && bus.out_ready;
            if (flush) begin
                q.delete();
            end else begin
                foreach (q[i]) q[i].t = (q[i].t == 0) ? 0 : q[i].t - 1;
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) begin
                    e.d = bus.in_data;
                    e.t = (int'(bus.in_tnew) == 0) ? 0 : int'(bus.in_tnew) - 1;
                    e.e = (bus.in_exc != '0) ? bus.in_exc : bus.stage_exc;
                    e.b = bus.in_bd;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic              x_valid;
        logic [DATA_W-1:0] x_data;
        logic [TNEW_W-1:0] x_tnew;
        logic [EXC_W-1:0]  x_exc;
        logic              x_bd;
        x_valid = (q.size() > 0);
        x_data  = '0;
        x_tnew  = '0;
        x_exc   = '0;
        x_bd    = 1'b0;
        if (x_valid) begin
            x_data = q[0].d;
            x_tnew = TNEW_W'(q[0].t);
            x_exc  = q[0].e;
            x_bd   = q[0].b;
        end
        check("model_out_valid", 256'(bus.out_valid), 256'(x_valid));
        check("model_in_ready",  256'(bus.in_ready),  256'(q.size() < 2));
        check("model_out_data",  256'(bus.out_data),  256'(x_data));
        check("model_out_tnew",  256'(bus.out_tnew),  256'(x_tnew));
        check("model_out_exc",   256'(bus.out_exc),   256'(x_exc));
        check("model_out_bd",    256'(bus.out_bd),    256'(x_bd));
    end

    task automatic put(input logic v, input logic [DATA_W-1:0] d, input int t,
                       input int ex, input int sx, input logic b);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_tnew   = TNEW_W'(t);
        bus.in_exc    = EXC_W'(ex);
        bus.stage_exc = EXC_W'(sx);
        bus.in_bd     = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] mk(input int i);
        return {32'h1000_0000 + 32'(i), 96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'(i * 3)};
    endfunction

    int tn_in [5] = '{2, 1, 0, 3, 2};
    int tn_exp[5] = '{1, 0, 0, 2, 1};
    int st_exp[5] = '{2, 1, 0, 0, 0};

    initial begin
        put(1'b0, '0, 0, 0, 0, 1'b0);
        bus.out_ready = 1'b0;
        #1;
        check("reset_out_valid", 256'(bus.out_valid), 256'd0);
        check("reset_in_ready",  256'(bus.in_ready),  256'd1);
        check("reset_out_data",  256'(bus.out_data),  256'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        step();

        // Streaming, one entry per cycle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put(1'b1, mk(i), tn_in[i], 0, 0, i[0]);
            step();
            check("stream_valid", 256'(bus.out_valid), 256'd1);
            check("stream_tnew",  256'(bus.out_tnew),  256'(tn_exp[i]));
            check("stream_data",  256'(bus.out_data),  256'(mk(i)));
        end
        put(1'b0, '0, 0, 0, 0, 1'b0);
        step();
        check("stream_drain", 256'(bus.out_valid), 256'd0);

        // Stall and skid.
        bus.out_ready = 1'b0;
        put(1'b1, mk(10), 0, 0, 0, 1'b0);
        step();
        check("skid_ready1", 256'(bus.in_ready), 256'd1);
        put(1'b1, mk(11), 0, 0, 0, 1'b1);
        step();
        check("skid_ready0", 256'(bus.in_ready), 256'd0);
        check("skid_head",   256'(bus.out_data), 256'(mk(10)));
        put(1'b1, mk(12), 0, 0, 0, 1'b0);
        step();
        check("skid_hold", 256'(bus.out_data), 256'(mk(10)));
        put(1'b0, '0, 0, 0, 0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        check("skid_second", 256'(bus.out_data), 256'(mk(11)));
        check("skid_bd",     256'(bus.out_bd),   256'd1);
        check("skid_reopen", 256'(bus.in_ready), 256'd1);
        step();
        check("skid_empty", 256'(bus.out_valid), 256'd0);

        // Tnew keeps counting while stalled.
        bus.out_ready = 1'b0;
        put(1'b1, mk(20), 3, 0, 0, 1'b0);
        step();
        put(1'b0, '0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("stall_tnew", 256'(bus.out_tnew), 256'(st_exp[i]));
            if (i < 4) step();
        end
        bus.out_ready = 1'b1;
        step();

        // Exception merge: the earlier exception wins.
        put(1'b1, mk(30), 0, 4, 12, 1'b0);
        step();
        check("exc_upstream", 256'(bus.out_exc), 256'd4);
        put(1'b1, mk(31), 0, 0, 12, 1'b0);
        step();
        check("exc_stage", 256'(bus.out_exc), 256'd12);
        put(1'b0, '0, 0, 0, 0, 1'b0);
        step();

        // Flush in ONE with a valid input: the input is discarded.
        bus.out_ready = 1'b0;
        put(1'b1, mk(40), 2, 0, 0, 1'b0);
        step();
        put(1'b1, mk(41), 2, 0, 0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        put(1'b0, '0, 0, 0, 0, 1'b0);
        check("flush1_valid", 256'(bus.out_valid), 256'd0);
        step();
        check("flush1_gone", 256'(bus.out_valid), 256'd0);

        // Flush in TWO with a valid input.
        put(1'b1, mk(50), 3, 1, 0, 1'b1);
        step();
        put(1'b1, mk(51), 3, 2, 0, 1'b1);
        step();
        check("flush2_full", 256'(bus.in_ready), 256'd0);
        put(1'b1, mk(52), 3, 3, 0, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        put(1'b0, '0, 0, 0, 0, 1'b0);
        check("flush2_valid", 256'(bus.out_valid), 256'd0);
        check("flush2_ready", 256'(bus.in_ready),  256'd1);
        check("flush2_data",  256'(bus.out_data),  256'd0);
        check("flush2_exc",   256'(bus.out_exc),   256'd0);
        bus.out_ready = 1'b1;
        step();
        check("flush2_gone", 256'(bus.out_valid), 256'd0);

        // Asynchronous reset mid-stream, in state TWO.
        bus.out_ready = 1'b0;
        put(1'b1, mk(60), 3, 0, 7, 1'b1);
        step();
        put(1'b1, mk(61), 3, 0, 7, 1'b1);
        step();
        #2 reset = 1'b0;
        #1;
        put(1'b0, '0, 0, 0, 0, 1'b0);
        check("rst_valid", 256'(bus.out_valid), 256'd0);
        check("rst_ready", 256'(bus.in_ready),  256'd1);
        check("rst_data",  256'(bus.out_data),  256'd0);
        check("rst_tnew",  256'(bus.out_tnew),  256'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        bus.out_ready = 1'b1;
        put(1'b1, mk(70), 2, 0, 9, 1'b0);
        step();
        check("rst_after_valid", 256'(bus.out_valid), 256'd1);
        check("rst_after_data",  256'(bus.out_data),  256'(mk(70)));
        check("rst_after_tnew",  256'(bus.out_tnew),  256'd1);
        check("rst_after_exc",   256'(bus.out_exc),   256'd9);
        put(1'b0, '0, 0, 0, 0, 1'b0);
        step();
        check("rst_after_drain", 256'(bus.out_valid), 256'd0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
